// File: rtl/parity_pkg.sv
// Shared types, constants and helpers for the parity stream checker.
package parity_pkg;

  // Frame tracking state: IDLE between frames, ACC while a frame is open.
  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } parity_state_t;

  // Parity mode encodings as seen on mode_odd.
  localparam logic PARITY_ODD  = 1'b1;
  localparam logic PARITY_EVEN = 1'b0;

  // Saturating increment of a counter that is 'width' bits wide.
  // Works on a 32-bit carrier so callers of any width up to 32 can share it.
  function automatic logic [31:0] sat_inc(input logic [31:0] value, input int width);
    logic [31:0] max_v;
    if (width >= 32) begin
      max_v = 32'hFFFF_FFFF;
    end else begin
      max_v = (32'd1 << width) - 32'd1;
    end
    if (value >= max_v) begin
      return max_v;
    end
    return value + 32'd1;
  endfunction

endpackage

// File: rtl/parity_reduce.sv
// Combinational XOR reduction of one data word down to a single parity bit.
module parity_reduce #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] data_i,
  output logic             parity_o
);

  // A set bit means the word holds an odd number of ones.
  assign parity_o = ^data_i;

endmodule

// File: rtl/parity_stream_checker.sv
// Running parity over a framed word stream with a received-parity check at
// end of frame. Reports parity, saturating word count and an error flag one
// cycle after the last word of each frame.
//
// Build option: define PARITY_STICKY_ERR_EN to make parity_err sticky until
// reset/clear and to add the err_frames failing-frame counter output.
//
// Handshake: a word is taken on any rising edge where in_valid is high and
// clear is low; there is no backpressure. in_last and in_chk are only looked
// at alongside in_valid. out_valid is a one-cycle pulse and the result fields
// hold their value until the next finished frame (or reset).
module parity_stream_checker
  import parity_pkg::*;
#(
  parameter int   WIDTH   = 8,
  parameter int   CNT_W   = 8,
  parameter logic ODD_DEF = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic             in_chk,
  input  logic             mode_odd,
  input  logic             clear,
  output logic             busy,
  output logic             out_valid,
  output logic             out_parity,
  output logic [CNT_W-1:0] out_count,
  output logic             parity_err,
`ifdef PARITY_STICKY_ERR_EN
  output logic [CNT_W-1:0] err_frames,
`endif
  output parity_state_t    state_dbg
);

  parity_state_t    state_q, state_d;
  logic             acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic             out_valid_q, out_valid_d;
  logic             out_parity_q, out_parity_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;
  logic             err_q, err_d;
`ifdef PARITY_STICKY_ERR_EN
  logic [CNT_W-1:0] err_frames_q, err_frames_d;
`endif

  logic             word_par;
  logic             frame_mode;
  logic             frame_parity;
  logic             frame_bad;
  logic [CNT_W-1:0] cnt_base;
  logic [CNT_W-1:0] cnt_inc;
  logic             acc_base;

  parity_reduce #(
    .WIDTH(WIDTH)
  ) u_reduce (
    .data_i  (in_data),
    .parity_o(word_par)
  );

  // Frame-level values for the word on the inputs this cycle. In IDLE the
  // frame starts from scratch and takes its mode straight from mode_odd.
  always_comb begin
    acc_base     = (state_q == ACC) ? acc_q : 1'b0;
    cnt_base     = (state_q == ACC) ? cnt_q : '0;
    frame_mode   = (state_q == ACC) ? mode_q : mode_odd;
    cnt_inc      = CNT_W'(sat_inc(32'(cnt_base), CNT_W));
    frame_parity = acc_base ^ word_par ^ frame_mode;
    frame_bad    = (in_chk != frame_parity);
  end

  // Next-state and result logic; clear wins over an accepted word.
  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    mode_d       = mode_q;
    out_valid_d  = 1'b0;
    out_parity_d = out_parity_q;
    out_count_d  = out_count_q;
    err_d        = err_q;
`ifdef PARITY_STICKY_ERR_EN
    err_frames_d = err_frames_q;
`endif

    if (clear) begin
      state_d = IDLE;
      acc_d   = 1'b0;
      cnt_d   = '0;
`ifdef PARITY_STICKY_ERR_EN
      err_d        = 1'b0;
      err_frames_d = '0;
`endif
    end else if (in_valid) begin
      if (state_q == IDLE) begin
        // Mode is captured only as a frame opens.
        mode_d = mode_odd;
      end
      if (in_last) begin
        // Frame ends: publish results and return to a clean IDLE.
        state_d      = IDLE;
        acc_d        = 1'b0;
        cnt_d        = '0;
        out_valid_d  = 1'b1;
        out_parity_d = frame_parity;
        out_count_d  = cnt_inc;
`ifdef PARITY_STICKY_ERR_EN
        err_d = err_q | frame_bad;
        if (frame_bad) begin
          err_frames_d = CNT_W'(sat_inc(32'(err_frames_q), CNT_W));
        end
`else
        err_d = frame_bad;
`endif
      end else begin
        state_d = ACC;
        acc_d   = acc_base ^ word_par;
        cnt_d   = cnt_inc;
      end
    end
  end

  // State and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      acc_q        <= 1'b0;
      cnt_q        <= '0;
      mode_q       <= ODD_DEF;
      out_valid_q  <= 1'b0;
      out_parity_q <= 1'b0;
      out_count_q  <= '0;
      err_q        <= 1'b0;
`ifdef PARITY_STICKY_ERR_EN
      err_frames_q <= '0;
`endif
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      mode_q       <= mode_d;
      out_valid_q  <= out_valid_d;
      out_parity_q <= out_parity_d;
      out_count_q  <= out_count_d;
      err_q        <= err_d;
`ifdef PARITY_STICKY_ERR_EN
      err_frames_q <= err_frames_d;
`endif
    end
  end

  assign busy       = (state_q == ACC);
  assign out_valid  = out_valid_q;
  assign out_parity = out_parity_q;
  assign out_count  = out_count_q;
  assign parity_err = err_q;
`ifdef PARITY_STICKY_ERR_EN
  assign err_frames = err_frames_q;
`endif
  assign state_dbg  = state_q;

endmodule

// File: doc/parity_stream_checker.md
Name: parity_stream_checker

Overview:
- Parametrised successor to the team's single-bit odd-parity FSM.
- Accumulates running parity over a framed stream of WIDTH-bit words with a valid/last handshake.
- Emits the frame parity and a word count, and checks a received parity bit at end of frame.
- Sits between a serial/word receiver and downstream frame logic as the integrity check stage.

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- CNT_W, 8, width of the per-frame word counter; the counter saturates.
- ODD_DEF, 1, reset value of the parity mode (1 = odd parity, 0 = even parity).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_data is valid this cycle.
- in_data  input  WIDTH  data word.
- in_last  input  1  marks the final word of a frame; qualified by in_valid.
- in_chk  input  1  received parity bit; sampled only with in_valid && in_last.
- mode_odd  input  1  parity mode; sampled only when state is IDLE.
- clear  input  1  synchronous abort: discards the current frame and returns to IDLE.
- busy  output  1  high in state ACC.
- out_valid  output  1  one-cycle pulse reporting a finished frame.
- out_parity  output  1  computed parity bit of the finished frame.
- out_count  output  CNT_W  number of words in the finished frame, saturating.
- parity_err  output  1  in_chk disagreed with out_parity; valid with out_valid.

Behaviour:
- Reset (asynchronous, active-high):
  - state = IDLE.
  - acc = 0, cnt = 0, mode register = ODD_DEF.
  - All outputs are 0, except out_count = 0 and parity_err = 0.
- States:
  - IDLE: no frame in progress.
  - ACC: accumulating words of a frame.
- Word reduction: w = XOR of all in_data bits.
- IDLE, in_valid && !in_last:
  - acc <= w, cnt <= 1, latch mode_odd, go to ACC.
- IDLE, in_valid && in_last (single-word frame):
  - Finish immediately using w.
  - Latch mode_odd for this frame; state stays IDLE.
- ACC, in_valid && !in_last:
  - acc <= acc ^ w.
  - cnt <= cnt + 1, saturating at 2^CNT_W - 1.
- ACC, in_valid && in_last:
  - Finish using acc ^ w; go to IDLE.
- Finish (takes effect on the next clock edge):
  - out_valid = 1 for exactly one cycle.
  - out_parity = final_xor ^ mode_odd_latched. Odd mode gives parity 1 when the data has an even number of ones, so that data plus parity has odd weight. This matches the existing FSM's toggle semantics when ODD=0.
  - out_count = cnt + 1, saturating.
  - parity_err = (in_chk != out_parity).
  - out_parity, out_count and parity_err hold until the next finish or reset.
- Latency: exactly 1 cycle from the in_last handshake to out_valid. Back-to-back frames are sustained with no bubble; a new frame's first word can arrive the cycle after its predecessor's last word.
- in_valid = 0: no state change; gaps inside a frame are allowed.
- mode_odd changes while in ACC are ignored.
- clear:
  - Takes priority over in_valid in the same cycle; that word is dropped.
  - acc <= 0, cnt <= 0, state <= IDLE.
  - No out_valid is generated; the held result outputs are unchanged.
- Count saturation: a frame longer than 2^CNT_W - 1 words reports out_count = 2^CNT_W - 1. Parity remains exact.
- Reset mid-frame: the frame is lost and no out_valid is produced.
- WIDTH = 1 degenerates to the existing x/y toggle behaviour with one input per cycle.

Optional Feature:
- Macro: PARITY_STICKY_ERR_EN.
- When defined:
  - parity_err is sticky: it sets on any failing frame and stays high across subsequent good frames.
  - It clears only on reset or clear.
  - An additional output err_frames [CNT_W-1:0] counts failing frames, saturating, and resets to 0 on reset/clear.
- When undefined:
  - parity_err reflects only the most recent finished frame.
  - There is no err_frames port.

Decomposition:
- Package parity_pkg:
  - State enum type parity_state_t {IDLE, ACC}.
  - Constant PARITY_ODD = 1'b1, PARITY_EVEN = 1'b0.
  - Function sat_inc(value, width) for the saturating increment.
- One sub-module, parity_reduce: combinational WIDTH-bit XOR reduction, instantiated once.
- Everything else lives in parity_stream_checker.

Test Plan:
- Reset mid-frame: assert reset after 2 words -> busy = 0, out_valid = 0 thereafter, outputs 0; next frame reports out_count = 1 for a single word.
- Odd mode, WIDTH = 8, frame {8'h03, 8'h01}, in_chk = 0:
  - out_valid pulses 1 cycle after last; out_parity = 0 (three ones, odd mode); out_count = 2; parity_err = 0.
  - Repeating with in_chk = 1 gives parity_err = 1.
- Even mode, single-word frame 8'hFF with in_last in IDLE, in_chk = 0 -> out_parity = 0, out_count = 1, parity_err = 0; busy never asserts.
- Back-to-back frames {8'h01}{8'h01, 8'h00} with no gap, odd mode:
  - Two out_valid pulses on consecutive frame ends.
  - Parities are 0 and 0; counts are 1 and 2.
- clear asserted together with in_valid on word 3 of 5 -> no out_valid; the next frame's count restarts at 1; mode_odd toggled in ACC has no effect on the frame parity.
- CNT_W = 2, frame of 6 words of 8'h01 -> out_count = 3 (saturated), out_parity = 1 in odd mode; with PARITY_STICKY_ERR_EN, a failing frame followed by a passing frame keeps parity_err = 1 and err_frames = 1.
